// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control sequencer: status encodings,
// button slot indices and the seconds roll-over value.
package stopwatch_ctrl_pkg;

    // Status encodings as seen on the status port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_FULL  = 2'b11
    } status_e;

    // Slot of each button in the conditioned button vector.
    localparam int unsigned BTN_START = 0;
    localparam int unsigned BTN_STOP  = 1;
    localparam int unsigned BTN_RESET = 2;
    localparam int unsigned BTN_COUNT = 3;

    // Last valid seconds value of the mm:ss counter.
    localparam int unsigned SEC_MAX = 59;

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// One push-button conditioner: 2-flop synchroniser, stability debounce and a
// single-cycle pulse on each accepted press (0->1 of the debounced level).
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic          r_level_d;
    logic [CW-1:0] r_cnt;

    // Synchronise, then accept the synced value only after it has disagreed
    // with the debounced level for DEB_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync    <= {r_sync[0], btn_raw};
            r_level_d <= r_level;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Release edges are deliberately dropped; only presses matter.
    assign press = r_level & ~r_level_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: conditions the three buttons, runs the
// IDLE/RUNNING/PAUSED/FULL machine, and produces the 1 s count enable and the
// counter clear for the mm:ss datapath, saturating at MAX_MIN:59.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned DEB_CYCLES = 1_000_000,
    parameter int unsigned MAX_MIN    = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       reset_btn,
    input  logic [7:0] minutes,
    input  logic [5:0] seconds,
    output logic       tick_en,
    output logic       count_clr,
    output logic [1:0] status
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [BTN_COUNT-1:0] w_raw;
    logic [BTN_COUNT-1:0] w_press;

    status_e       r_state;
    status_e       w_state_next;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_next;
    logic          r_count_clr;
    logic          w_count_clr_next;
    logic          w_tick;
    logic          w_due;
    logic          w_sat;
    logic          w_reset_win;
    logic          w_stop_win;
    logic          w_start_win;

    assign w_raw[BTN_START] = start_btn;
    assign w_raw[BTN_STOP]  = stop_btn;
    assign w_raw[BTN_RESET] = reset_btn;

    genvar gi;
    generate
        for (gi = 0; gi < BTN_COUNT; gi++) begin : g_btn
            btn_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk    (clk),
                .rst_n  (rst_n),
                .btn_raw(w_raw[gi]),
                .press  (w_press[gi])
            );
        end
    endgenerate

    // Only one press acts per cycle: reset beats stop beats start.
    assign w_reset_win = w_press[BTN_RESET];
    assign w_stop_win  = w_press[BTN_STOP] & ~w_press[BTN_RESET];
    assign w_start_win = w_press[BTN_START] & ~w_press[BTN_STOP] & ~w_press[BTN_RESET];

    // A second boundary is due on the last prescaler count while running;
    // it is swallowed instead of advancing past MAX_MIN:59.
    assign w_due = (r_state == ST_RUN) && (r_presc == PRE_LAST);
    assign w_sat = (minutes == 8'(MAX_MIN)) && (seconds == 6'(SEC_MAX));

    // Next state, clear request, prescaler and tick decision.
    always_comb begin
        w_state_next     = r_state;
        w_count_clr_next = 1'b0;
        w_tick           = 1'b0;
        w_presc_next     = r_presc;
        if (r_state == ST_RUN) begin
            w_presc_next = (r_presc == PRE_LAST) ? '0 : r_presc + PW'(1);
        end
        if (w_reset_win) begin
            w_state_next     = ST_IDLE;
            w_count_clr_next = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_win) begin
                        w_state_next = ST_RUN;
                        w_presc_next = '0;
                    end
                end
                ST_RUN: begin
                    if (w_due && w_sat) begin
                        w_state_next = ST_FULL;
                    end else begin
                        w_tick = w_due;
                        if (w_stop_win) begin
                            w_state_next = ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (w_start_win) begin
                        w_state_next = ST_RUN;
                    end
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end
    end

    // State, prescaler and the registered clear pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_presc     <= '0;
            r_count_clr <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_presc     <= w_presc_next;
            r_count_clr <= w_count_clr_next;
        end
    end

    assign tick_en   = w_tick;
    assign count_clr = r_count_clr;
    assign status    = r_state;

endmodule
